player_select_ctrl: RTL and testbench
=====================================

PLAYER_SELECT_CTRL -- requirements
Module: player_select_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000: stable-input cycles needed to accept a button level change.
REQ-002 SHALL have parameter NUM_CHOICES, default 6: number of selectable values, range 2..8.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sel  input  1  raw asynchronous select button, high = pressed.
REQ-006 SHALL have port conf  input  1  raw asynchronous confirm button, high = pressed.
REQ-007 SHALL have port start  input  1  raw asynchronous game-start level.
REQ-008 SHALL have port choice  output  3  current selection, 0..NUM_CHOICES-1.
REQ-009 SHALL have port sel_pulse  output  1  one-cycle strobe for each accepted select press.
REQ-010 SHALL have port locked  output  1  high once the choice is confirmed.
REQ-011 SHALL have port active  output  1  high while in the PLAY state.

Function
REQ-012 SHALL pass sel, conf and start each through a 2-flop synchronizer before any other use.
REQ-013 SHALL debounce synchronized sel and conf separately: counter clears when sync input equals stable level, else increments; stable level flips when counter reaches DEBOUNCE_CYCLES-1.
REQ-014 SHALL generate a press event on the cycle after the debounced level goes 0->1; release (1->0) generates nothing.
REQ-015 SHALL make a press event appear 2 + DEBOUNCE_CYCLES + 1 cycles after a clean raw rising edge.
REQ-016 SHALL ignore any raw pulse shorter than DEBOUNCE_CYCLES cycles: no event, stable level unchanged.
REQ-017 SHALL use start after synchronization only, with no debounce, as a level.
REQ-018 SHALL implement a 3-state FSM: SELECT, LOCKED, PLAY.
REQ-019 SHALL, in SELECT on a sel press, set choice to choice+1, or to 0 when choice = NUM_CHOICES-1 (wrap-around), and assert sel_pulse for that one cycle.
REQ-020 SHALL, in SELECT on a conf press, move to LOCKED with choice frozen.
REQ-021 SHALL, when sel and conf press events occur in the same cycle in SELECT, go to LOCKED with choice not incremented and sel_pulse low.
REQ-022 SHALL ignore start while in SELECT.
REQ-023 SHALL, in LOCKED, ignore sel and conf presses (sel_pulse stays low) and move to PLAY on the first cycle synchronized start is high.
REQ-024 SHALL keep PLAY until rst; all buttons are ignored there.
REQ-025 SHALL drive outputs as registered signals: locked = (state != SELECT), active = (state == PLAY).
REQ-026 SHALL keep a button held across the SELECT->LOCKED transition from producing a later event when returning to SELECT (only reachable via reset).

Reset
REQ-027 SHALL on rst set state=SELECT, choice=0, sel_pulse=0, locked=0, active=0.
REQ-028 SHALL on rst clear synchronizer flops, debounce counters and stable levels to 0.
REQ-029 SHALL let rst take effect mid-debounce or mid-press with no event emitted, and produce no press event on the first cycle after rst if a button is held (only a 0->1 debounced edge counts).

Structure
REQ-030 SHALL place state encoding (SELECT/LOCKED/PLAY) and the default DEBOUNCE_CYCLES value in a shared package game_pkg.
REQ-031 SHALL implement synchronizer+debouncer+edge detector as a sub-module button_debounce (ports clk, rst, raw, level, press), instantiated twice.
REQ-032 SHALL size the debounce counter as $clog2(DEBOUNCE_CYCLES) bits.

Verification (DEBOUNCE_CYCLES=4, NUM_CHOICES=6)
REQ-033 SHALL cover: sel high 20 cycles -> exactly one sel_pulse, 7 cycles after the edge; choice 0->1.
REQ-034 SHALL cover: sel glitch high 2 cycles -> no sel_pulse, choice stays 0.
REQ-035 SHALL cover: 7 clean sel presses -> choice sequence 1,2,3,4,5,0,1.
REQ-036 SHALL cover: 3 sel presses, conf press, 2 more sel presses -> locked=1, choice=3, no sel_pulse after lock.
REQ-037 SHALL cover: start high in SELECT -> active=0; then conf press, start high -> active=1 within 3 cycles of start.
REQ-038 SHALL cover: sel and conf raised same cycle -> locked=1, choice unchanged; rst mid-debounce -> all outputs 0, no pulse.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants for the player-select controller: FSM state encoding
// and the default debounce length.
package game_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    localparam logic [1:0] ST_SELECT = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_PLAY   = 2'd2;

endpackage

// File: rtl/player_select_ctrl_if.sv
// Bundle of the player-select controller's user-facing signals; master
// drives the buttons, slave is the controller side.
interface player_select_ctrl_if;

    logic       sel;
    logic       conf;
    logic       start;
    logic [2:0] choice;
    logic       sel_pulse;
    logic       locked;
    logic       active;

    modport master (
        output sel, conf, start,
        input  choice, sel_pulse, locked, active
    );

    modport slave (
        input  sel, conf, start,
        output choice, sel_pulse, locked, active
    );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer, counter debouncer and rising-edge detector for
// one raw button; press is high for the one cycle after level rises.
module button_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples its pre-edge inputs, making the synchronizer chain a real two-stage delay.
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= stable_q;
        end
    end

    assign level = stable_q;
    assign press = stable_q & ~prev_q;

endmodule

// File: rtl/player_select_ctrl.sv
// Player selection controller: cycle a choice with the select button,
// lock it with confirm, then enter play when the start level is seen.
module player_select_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int NUM_CHOICES     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       conf,
    input  logic       start,
    output logic [2:0] choice,
    output logic       sel_pulse,
    output logic       locked,
    output logic       active
);

    localparam logic [2:0] CHOICE_LAST = 3'(NUM_CHOICES - 1);

    logic       sel_press;
    logic       conf_press;
    logic       sel_level;
    logic       conf_level;
    logic       unused_levels;
    logic       start_s1_q;
    logic       start_s2_q;
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [2:0] choice_q;
    logic [2:0] choice_d;
    logic       sel_pulse_q;
    logic       sel_pulse_d;
    logic       locked_q;
    logic       active_q;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (sel),
        .level (sel_level),
        .press (sel_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_conf_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (conf),
        .level (conf_level),
        .press (conf_press)
    );

    assign unused_levels = sel_level ^ conf_level;

    always_comb begin
        state_d     = state_q;
        choice_d    = choice_q;
        sel_pulse_d = 1'b0;
        case (state_q)
            ST_SELECT: begin
                // Confirm wins over a simultaneous select: lock without incrementing.
                if (conf_press) begin
                    state_d = ST_LOCKED;
                end else if (sel_press) begin
                    choice_d    = (choice_q == CHOICE_LAST) ? 3'd0 : choice_q + 3'd1;
                    sel_pulse_d = 1'b1;
                end
            end
            ST_LOCKED: if (start_s2_q) state_d = ST_PLAY;
            ST_PLAY:   state_d = ST_PLAY;
            default:   state_d = ST_SELECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_s1_q  <= 1'b0;
            start_s2_q  <= 1'b0;
            state_q     <= ST_SELECT;
            choice_q    <= 3'd0;
            sel_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            start_s1_q  <= start;
            start_s2_q  <= start_s1_q;
            state_q     <= state_d;
            choice_q    <= choice_d;
            sel_pulse_q <= sel_pulse_d;
            locked_q    <= (state_d != ST_SELECT);
            active_q    <= (state_d == ST_PLAY);
        end
    end

    assign choice    = choice_q;
    assign sel_pulse = sel_pulse_q;
    assign locked    = locked_q;
    assign active    = active_q;

endmodule

// File: tb/tb_player_select_ctrl.sv
// Self-checking bench for player_select_ctrl with DEBOUNCE_CYCLES=4, NUM_CHOICES=6:
// an event-level model compared every cycle, plus directed literal checks.
module tb_player_select_ctrl;

    localparam int D = 4;
    localparam int N = 6;
    localparam int HIST = 4096;

    typedef enum int {M_SELECT, M_LOCKED, M_PLAY} m_state_t;

    logic clk = 1'b0;
    logic rst;

    player_select_ctrl_if bus ();

    player_select_ctrl #(.DEBOUNCE_CYCLES(D), .NUM_CHOICES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (bus.sel),
        .conf      (bus.conf),
        .start     (bus.start),
        .choice    (bus.choice),
        .sel_pulse (bus.sel_pulse),
        .locked    (bus.locked),
        .active    (bus.active)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int pulse_cnt = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // ---------------- behavioural model ----------------
    // Raw samples are recorded per clock edge; a button's accepted level flips
    // once the value seen two edges late has disagreed with it for D edges in a
    // row since its last flip. A 0->1 flip is a press acted on at the next edge.
    bit       hist_btn [2][HIST];
    bit       hist_start [HIST];
    bit       stable [2];
    int       last_flip [2];
    bit       pend [2];
    int       cyc = 8;
    bit       model_valid = 1'b0;
    m_state_t m_state = M_SELECT;
    int       m_choice = 0;
    bit       m_pulse = 1'b0;
    bit       sel_ev, conf_ev, start_x;

    function automatic bit should_flip(input int b, input int e);
        if (e - last_flip[b] < D) return 1'b0;
        for (int j = 0; j < D; j++)
            if (hist_btn[b][e-2-j] == stable[b]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (cyc < HIST - 1) begin
            hist_btn[0][cyc] = bus.sel;
            hist_btn[1][cyc] = bus.conf;
            hist_start[cyc]  = bus.start;
            if (rst) begin
                for (int b = 0; b < 2; b++) begin
                    hist_btn[b][cyc]   = 1'b0;
                    hist_btn[b][cyc-1] = 1'b0;
                    stable[b]    = 1'b0;
                    last_flip[b] = cyc;
                    pend[b]      = 1'b0;
                end
                hist_start[cyc]   = 1'b0;
                hist_start[cyc-1] = 1'b0;
                m_state     = M_SELECT;
                m_choice    = 0;
                m_pulse     = 1'b0;
                model_valid = 1'b1;
            end else if (model_valid) begin
                sel_ev  = pend[0];
                conf_ev = pend[1];
                for (int b = 0; b < 2; b++) begin
                    if (should_flip(b, cyc)) begin
                        stable[b]    = !stable[b];
                        last_flip[b] = cyc;
                        pend[b]      = stable[b];
                    end else begin
                        pend[b] = 1'b0;
                    end
                end
                start_x = hist_start[cyc-2];
                m_pulse = 1'b0;
                case (m_state)
                    M_SELECT: begin
                        if (conf_ev) m_state = M_LOCKED;
                        else if (sel_ev) begin
                            m_choice = (m_choice + 1) % N;
                            m_pulse  = 1'b1;
                        end
                    end
                    M_LOCKED: if (start_x) m_state = M_PLAY;
                    default:  m_state = M_PLAY;
                endcase
            end
            cyc++;
        end
    end

    // One compare process, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("model_choice",    int'(bus.choice),    m_choice);
            check("model_sel_pulse", int'(bus.sel_pulse), int'(m_pulse));
            check("model_locked",    int'(bus.locked),    int'(m_state != M_SELECT));
            check("model_active",    int'(bus.active),    int'(m_state == M_PLAY));
            if (bus.sel_pulse === 1'b1) pulse_cnt++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.sel = 1'b0; bus.conf = 1'b0; bus.start = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic press_sel();
        bus.sel = 1'b1; step(10);
        bus.sel = 1'b0; step(12);
    endtask

    task automatic press_conf();
        bus.conf = 1'b1; step(10);
        bus.conf = 1'b0; step(12);
    endtask

    int exp_seq [7] = '{1, 2, 3, 4, 5, 0, 1};
    int base;

    initial begin
        rst = 1'b1;
        bus.sel = 1'b0; bus.conf = 1'b0; bus.start = 1'b0;
        step(3);
        check("reset_choice",    int'(bus.choice),    0);
        check("reset_sel_pulse", int'(bus.sel_pulse), 0);
        check("reset_locked",    int'(bus.locked),    0);
        check("reset_active",    int'(bus.active),    0);
        rst = 1'b0;
        step(2);

        // Glitch of 2 cycles is rejected.
        base = pulse_cnt;
        bus.sel = 1'b1; step(2);
        bus.sel = 1'b0; step(12);
        check("glitch_no_pulse", pulse_cnt - base, 0);
        check("glitch_choice",   int'(bus.choice), 0);

        // Clean 20-cycle press: exactly one pulse, 7 cycles after the edge.
        base = pulse_cnt;
        bus.sel = 1'b1;
        step(6);
        check("press_pulse_early", int'(bus.sel_pulse), 0);
        step(1);
        check("press_pulse_at_7",  int'(bus.sel_pulse), 1);
        check("press_choice_1",    int'(bus.choice),    1);
        step(1);
        check("press_pulse_once",  int'(bus.sel_pulse), 0);
        step(12);
        bus.sel = 1'b0; step(12);
        check("press_pulse_count", pulse_cnt - base, 1);

        // Seven presses wrap through NUM_CHOICES.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            press_sel();
            check($sformatf("seq_choice_%0d", i), int'(bus.choice), exp_seq[i]);
        end

        // Presses after confirm are ignored.
        do_reset();
        repeat (3) press_sel();
        press_conf();
        check("lock_locked", int'(bus.locked), 1);
        check("lock_choice", int'(bus.choice), 3);
        base = pulse_cnt;
        repeat (2) press_sel();
        check("lock_choice_frozen", int'(bus.choice), 3);
        check("lock_no_pulse",      pulse_cnt - base, 0);
        check("lock_not_active",    int'(bus.active), 0);

        // Start ignored in SELECT, honoured after confirm.
        do_reset();
        bus.start = 1'b1; step(12);
        check("start_in_select_active", int'(bus.active), 0);
        check("start_in_select_locked", int'(bus.locked), 0);
        bus.start = 1'b0; step(4);
        press_conf();
        bus.start = 1'b1; step(3);
        check("start_play_active", int'(bus.active), 1);
        bus.start = 1'b0;
        press_sel();
        press_conf();
        check("play_holds_active", int'(bus.active), 1);
        check("play_holds_choice", int'(bus.choice), 0);

        // Simultaneous select and confirm: lock, no increment.
        do_reset();
        press_sel();
        base = pulse_cnt;
        bus.sel = 1'b1; bus.conf = 1'b1; step(10);
        bus.sel = 1'b0; bus.conf = 1'b0; step(12);
        check("both_locked",   int'(bus.locked), 1);
        check("both_choice",   int'(bus.choice), 1);
        check("both_no_pulse", pulse_cnt - base, 0);

        // Reset mid-debounce: all outputs cleared, no pulse afterwards.
        do_reset();
        base = pulse_cnt;
        bus.sel = 1'b1; step(4);
        rst = 1'b1; bus.sel = 1'b0; step(1);
        rst = 1'b0;
        check("middb_choice",    int'(bus.choice),    0);
        check("middb_sel_pulse", int'(bus.sel_pulse), 0);
        check("middb_locked",    int'(bus.locked),    0);
        check("middb_active",    int'(bus.active),    0);
        step(12);
        check("middb_no_pulse",  pulse_cnt - base, 0);

        // Button held through reset: no immediate event, one debounced event later.
        base = pulse_cnt;
        bus.sel = 1'b1; rst = 1'b1; step(1);
        rst = 1'b0; step(1);
        check("held_rst_no_pulse", int'(bus.sel_pulse), 0);
        step(12);
        bus.sel = 1'b0; step(12);
        check("held_rst_choice",   int'(bus.choice), 1);
        check("held_rst_one",      pulse_cnt - base, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
